pwm_seq_ctrl: RTL and testbench
===============================

# pwm_seq_ctrl

Duty-cycle sequencer that feeds the 4-channel PWM compare registers (CR0..CR3) from a FIFO of duty vectors. Each new vector is applied only at a PWM period boundary. Each vector is held for a programmable number of periods. The block sits between a DMA or software push port and the PWM compare inputs, and enables glitch-free waveform playback (LED fades, motor ramps) without per-period CPU intervention.

## Interface
- CHN, 4: number of PWM channels per duty vector.
- CRX_WIDTH, 32: width of one channel compare value.
- DEPTH, 8: FIFO depth in vectors; must be a power of 2 and at least 2.
- REP_WIDTH, 8: width of the repeat count.
- clk_i  in  1  clock; the PWM register clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  1-cycle pulse; arms playback.
- stop_i  in  1  1-cycle pulse; ends playback at the next period boundary.
- flush_i  in  1  1-cycle pulse; empties the FIFO. Honoured only in IDLE.
- clr_i  in  1  1-cycle pulse; clears underflow_o.
- rep_i  in  REP_WIDTH  each vector is held for rep_i+1 periods; sampled when a vector is loaded.
- period_end_i  in  1  1-cycle pulse when the PWM counter wraps, already synchronous to clk_i.
- dat_valid_i  in  1  push request.
- dat_ready_o  out  1  FIFO not full.
- dat_i  in  CHN*CRX_WIDTH  duty vector; channel n occupies bits [n*CRX_WIDTH +: CRX_WIDTH].
- cr_o  out  CHN*CRX_WIDTH  applied compare values; registered.
- cr_upd_o  out  1  1-cycle pulse in the cycle cr_o takes a new vector.
- busy_o  out  1  state is ARM or RUN.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- underflow_o  out  1  sticky; a vector was due but the FIFO was empty.

## Operation
- FIFO:
  - Push occurs when dat_valid_i && dat_ready_o.
  - dat_ready_o = (level_o != DEPTH), decoded from the registered level.
  - Pop is internal, happens only on a load, and is never issued when the FIFO is empty.
  - Push and pop in the same cycle leave level_o unchanged.
  - There is no bypass: a vector pushed in cycle N is poppable from cycle N+1.
- State machine has three states: IDLE, ARM, RUN.
  - IDLE:
    - cr_o holds its value.
    - start_i moves to ARM.
    - flush_i zeroes the read/write pointers and level_o.
    - period_end_i is ignored.
  - ARM: on period_end_i, with the FIFO non-empty:
    - pop the head into cr_o;
    - rep_cnt <= rep_i;
    - pulse cr_upd_o;
    - go to RUN.
    - With the FIFO empty, stay in ARM; no underflow is flagged.
  - RUN: on period_end_i:
    - If rep_cnt != 0, decrement rep_cnt; cr_o is unchanged.
    - Else, if the FIFO is non-empty, pop, load cr_o, reload rep_cnt from rep_i, and pulse cr_upd_o.
    - Else, set underflow_o, hold cr_o and rep_cnt=0, and stay in RUN. The next pushed vector loads at a later boundary.
  - stop_i in ARM or RUN sets stop_pend. At the next period_end_i the block goes to IDLE with no load; cr_o keeps the last vector.
- Simultaneous events:
  - stop_i and start_i in the same cycle: stop wins. In IDLE neither has effect.
  - start_i in IDLE together with period_end_i: the block enters ARM, and that boundary is not used for a load.
  - stop_pend set and period_end_i in the same cycle: go to IDLE; no pop.
  - clr_i and an underflow event in the same cycle: the set wins; underflow_o stays 1.
  - flush_i outside IDLE is ignored.
- Arithmetic: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. rep_cnt saturates at 0 and never wraps.

## Timing
- Reset values:
  - state = IDLE;
  - cr_o = 0, cr_upd_o = 0, busy_o = 0;
  - level_o = 0, so dat_ready_o = 1 immediately after reset;
  - underflow_o = 0, rep_cnt = 0, stop_pend = 0;
  - FIFO pointers = 0.
- Reset asserted mid-playback discards the FIFO contents and stop_pend.
- Load latency: cr_o and cr_upd_o change in cycle N+1 when period_end_i is high in cycle N.
- level_o and dat_ready_o update one cycle after a push or pop.
- busy_o rises one cycle after start_i. It falls one cycle after the terminating period_end_i.
- underflow_o rises in cycle N+1 for an empty boundary in cycle N. It clears one cycle after clr_i.
- All outputs are registered except dat_ready_o, which is a decode of registered level_o.

## Test plan
- Basic playback, with rep_i=0:
  - Stimulus: push vectors A={10,20,30,40} and B={50,60,70,80}; start_i; then 3 period_end_i pulses.
  - Required: cr_o=A one cycle after pulse 1, then B after pulse 2, with a cr_upd_o pulse at each load. Pulse 3 sets underflow_o=1 and cr_o stays B.
- Repeat count, with rep_i=2 and one vector A:
  - Required: A loads at pulse 1; cr_o is unchanged at pulses 2 and 3; underflow_o=1 only after pulse 4.
- Full FIFO, with DEPTH=8:
  - Push 8 vectors: level_o=8 and dat_ready_o=0; a 9th push is not accepted.
  - A pop at a boundary while dat_valid_i is held: level_o=7 for one cycle, then the push lands and level_o returns to 8.
- Stop and flush:
  - In RUN, pulse stop_i: the next period_end_i causes no load and busy_o=0.
  - flush_i in IDLE gives level_o=0.
  - flush_i asserted during RUN leaves level_o unchanged.
- Edge cases:
  - start_i coincident with period_end_i in IDLE: no load at that pulse; the load happens at the following pulse.
  - clr_i coincident with an underflow event: underflow_o stays 1.
  - rst_n_i dropped mid-RUN: cr_o=0, level_o=0, and IDLE within the same cycle.

Source files
------------

// File: rtl/pwm_seq_ctrl.sv
// Duty-vector sequencer: FIFO of CHN-channel compare vectors applied to cr_o at PWM period boundaries.
// Latency: cr_o/cr_upd_o update 1 cycle after the period_end_i that loads; level_o 1 cycle after push/pop.
// Backpressure: dat_ready_o drops while the FIFO holds DEPTH vectors; pushes are dropped only by the producer.
module pwm_seq_ctrl #(
  parameter int CHN       = 4,
  parameter int CRX_WIDTH = 32,
  parameter int DEPTH     = 8,
  parameter int REP_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic                          flush_i,
  input  logic                          clr_i,
  input  logic [REP_WIDTH-1:0]          rep_i,
  input  logic                          period_end_i,
  input  logic                          dat_valid_i,
  output logic                          dat_ready_o,
  input  logic [CHN*CRX_WIDTH-1:0]      dat_i,
  output logic [CHN*CRX_WIDTH-1:0]      cr_o,
  output logic                          cr_upd_o,
  output logic                          busy_o,
  output logic [$clog2(DEPTH):0]        level_o,
  output logic                          underflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int VW = CHN * CRX_WIDTH;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [VW-1:0]        r_mem [DEPTH];
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [LW-1:0]        r_level;
  logic [REP_WIDTH-1:0] r_rep_cnt;
  logic                 r_stop_pend;
  logic                 r_underflow;
  logic                 r_cr_upd;
  logic                 r_busy;
  logic [VW-1:0]        r_cr;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_flush;
  logic                 w_dec;
  logic                 w_uf_set;
  logic                 w_stop_pend_nxt;

  assign w_empty     = (r_level == '0);
  assign dat_ready_o = (r_level != FULL_LVL);
  assign w_push      = dat_valid_i && dat_ready_o;

  assign cr_o        = r_cr;
  assign cr_upd_o    = r_cr_upd;
  assign busy_o      = r_busy;
  assign level_o     = r_level;
  assign underflow_o = r_underflow;

  // Next-state and boundary actions; a pending stop takes priority over any load at the boundary
  always_comb begin
    w_state_nxt     = r_state;
    w_pop           = 1'b0;
    w_dec           = 1'b0;
    w_uf_set        = 1'b0;
    w_flush         = 1'b0;
    w_stop_pend_nxt = r_stop_pend;
    case (r_state)
      IDLE: begin
        w_stop_pend_nxt = 1'b0;
        w_flush         = flush_i;
        // stop_i alongside start_i cancels the start
        if (start_i && !stop_i) begin
          w_state_nxt = ARM;
        end
      end
      ARM, RUN: begin
        if (stop_i) begin
          w_stop_pend_nxt = 1'b1;
        end
        if (period_end_i) begin
          if (r_stop_pend) begin
            w_state_nxt     = IDLE;
            w_stop_pend_nxt = 1'b0;
          end else if (r_state == RUN && r_rep_cnt != '0) begin
            w_dec = 1'b1;
          end else if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = RUN;
          end else if (r_state == RUN) begin
            // ARM waits silently for the first vector; only RUN reports a starved boundary
            w_uf_set = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register plus pending-stop and busy flags
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_stop_pend <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stop_pend <= w_stop_pend_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  // FIFO storage; entries are only read when the level marks them valid, so no reset is needed
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= dat_i;
    end
  end

  // FIFO pointers and occupancy; flush only reaches here from IDLE, where no pop can occur
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Applied compare vector, its update strobe and the per-vector repeat counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cr      <= '0;
      r_cr_upd  <= 1'b0;
      r_rep_cnt <= '0;
    end else begin
      r_cr_upd <= w_pop;
      if (w_pop) begin
        r_cr      <= r_mem[r_rptr];
        r_rep_cnt <= rep_i;
      end else if (w_dec) begin
        r_rep_cnt <= r_rep_cnt - REP_WIDTH'(1);
      end
    end
  end

  // Sticky underflow flag; a new underflow beats a simultaneous clear
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_underflow <= 1'b0;
    end else if (w_uf_set) begin
      r_underflow <= 1'b1;
    end else if (clr_i) begin
      r_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Self-checking bench for pwm_seq_ctrl: directed scenarios plus random traffic against a queue-based model.
// The driver advances one cycle per tick and publishes expectations; a negedge monitor compares.
// Load expectations travel through a scoreboard queue consumed whenever an update is due or seen.
module tb_pwm_seq_ctrl;

  localparam int CHN   = 4;
  localparam int CRXW  = 32;
  localparam int DEPTH = 8;
  localparam int REPW  = 8;
  localparam int VW    = CHN * CRXW;

  logic            clk_i;
  logic            rst_n_i;
  logic            start_i;
  logic            stop_i;
  logic            flush_i;
  logic            clr_i;
  logic [REPW-1:0] rep_i;
  logic            period_end_i;
  logic            dat_valid_i;
  logic            dat_ready_o;
  logic [VW-1:0]   dat_i;
  logic [VW-1:0]   cr_o;
  logic            cr_upd_o;
  logic            busy_o;
  logic [3:0]      level_o;
  logic            underflow_o;

  pwm_seq_ctrl #(
    .CHN       (CHN),
    .CRX_WIDTH (CRXW),
    .DEPTH     (DEPTH),
    .REP_WIDTH (REPW)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .flush_i      (flush_i),
    .clr_i        (clr_i),
    .rep_i        (rep_i),
    .period_end_i (period_end_i),
    .dat_valid_i  (dat_valid_i),
    .dat_ready_o  (dat_ready_o),
    .dat_i        (dat_i),
    .cr_o         (cr_o),
    .cr_upd_o     (cr_upd_o),
    .busy_o       (busy_o),
    .level_o      (level_o),
    .underflow_o  (underflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp;
  int n_bad;

  // Behavioural model: playback mode, a queue of vectors, periods left to hold, pending stop
  typedef enum {M_IDLE, M_ARM, M_RUN} mode_t;
  mode_t          m_mode;
  logic [VW-1:0]  m_q[$];
  logic [VW-1:0]  m_cr;
  int             m_hold;
  bit             m_pend;
  bit             m_uf;
  bit             m_ld;
  logic [VW-1:0]  m_ld_v;

  // Published expectations for the cycle after the most recent edge
  logic [VW-1:0]  exp_q[$];
  logic [VW-1:0]  e_cr;
  int             e_level;
  bit             e_busy;
  bit             e_uf;
  bit             mon_en;

  task automatic cmp(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_q.delete();
    m_cr   = '0;
    m_hold = 0;
    m_pend = 1'b0;
    m_uf   = 1'b0;
    m_ld   = 1'b0;
    exp_q.delete();
    e_cr    = '0;
    e_level = 0;
    e_busy  = 1'b0;
    e_uf    = 1'b0;
  endtask

  // Apply this cycle's inputs to the model; results become visible after the coming edge
  task automatic model_step();
    bit acc;
    bit was_pend;
    bit uf_set;
    acc      = dat_valid_i && (m_q.size() < DEPTH);
    was_pend = m_pend;
    uf_set   = 1'b0;
    m_ld     = 1'b0;
    if (m_mode == M_IDLE) begin
      if (flush_i) begin
        m_q.delete();
        acc = 1'b0;
      end
      if (start_i && !stop_i) m_mode = M_ARM;
    end else begin
      if (stop_i) m_pend = 1'b1;
      if (period_end_i) begin
        if (was_pend) begin
          m_mode = M_IDLE;
          m_pend = 1'b0;
        end else if (m_mode == M_RUN && m_hold > 0) begin
          m_hold = m_hold - 1;
        end else if (m_q.size() > 0) begin
          m_ld_v = m_q.pop_front();
          m_ld   = 1'b1;
          m_cr   = m_ld_v;
          m_hold = int'(rep_i);
          m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
          uf_set = 1'b1;
        end
      end
    end
    if (acc) m_q.push_back(dat_i);
    if (uf_set) m_uf = 1'b1;
    else if (clr_i) m_uf = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
    if (m_ld) exp_q.push_back(m_ld_v);
    e_cr         = m_cr;
    e_level      = m_q.size();
    e_busy       = (m_mode != M_IDLE);
    e_uf         = m_uf;
    start_i      = 1'b0;
    stop_i       = 1'b0;
    flush_i      = 1'b0;
    clr_i        = 1'b0;
    period_end_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [VW-1:0] v);
    dat_valid_i = 1'b1;
    dat_i       = v;
    tick();
    dat_valid_i = 1'b0;
  endtask

  task automatic pe();
    period_end_i = 1'b1;
    tick();
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: scoreboard for loads plus per-cycle status comparison
  always @(negedge clk_i) begin
    if (mon_en) begin
      logic [VW-1:0] v;
      cmp("cr_upd", {{(VW-1){1'b0}}, cr_upd_o}, {{(VW-1){1'b0}}, (exp_q.size() != 0)});
      if (exp_q.size() != 0) begin
        v = exp_q.pop_front();
        cmp("cr_load", cr_o, v);
      end
      cmp("cr_o", cr_o, e_cr);
      cmp("level", VW'(level_o), VW'(e_level));
      cmp("ready", VW'(dat_ready_o), VW'(e_level != DEPTH));
      cmp("busy", VW'(busy_o), VW'(e_busy));
      cmp("underflow", VW'(underflow_o), VW'(e_uf));
    end
  end

  initial begin
    logic [VW-1:0] va;
    logic [VW-1:0] vb;
    logic [VW-1:0] vs;
    n_cmp = 0;
    n_bad = 0;
    mon_en       = 1'b0;
    rst_n_i      = 1'b1;
    start_i      = 1'b0;
    stop_i       = 1'b0;
    flush_i      = 1'b0;
    clr_i        = 1'b0;
    rep_i        = '0;
    period_end_i = 1'b0;
    dat_valid_i  = 1'b0;
    dat_i        = '0;
    model_reset();
    #1 rst_n_i = 1'b0;
    #2;
    cmp("rst_cr", cr_o, '0);
    cmp("rst_upd", VW'(cr_upd_o), '0);
    cmp("rst_busy", VW'(busy_o), '0);
    cmp("rst_level", VW'(level_o), '0);
    cmp("rst_ready", VW'(dat_ready_o), VW'(1));
    cmp("rst_uf", VW'(underflow_o), '0);
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    mon_en = 1'b1;

    // Basic playback, single-period hold
    va = {32'd40, 32'd30, 32'd20, 32'd10};
    vb = {32'd80, 32'd70, 32'd60, 32'd50};
    rep_i = 8'd0;
    push(va);
    push(vb);
    start_i = 1'b1; tick();
    idle(2); pe(); idle(2); pe(); idle(2); pe(); idle(2);
    cmp("basic_uf", VW'(underflow_o), VW'(1));
    cmp("basic_cr_b", cr_o, vb);
    clr_i = 1'b1; tick();
    idle(1);
    cmp("clr_uf", VW'(underflow_o), '0);

    // Stop in RUN: next boundary returns to IDLE without a load
    stop_i = 1'b1; tick();
    idle(1); pe(); idle(1);
    cmp("stop_busy", VW'(busy_o), '0);

    // Repeat count of 2: vector held for three periods
    rep_i = 8'd2;
    va = rnd_vec();
    push(va);
    start_i = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      idle(2); pe();
    end
    idle(1);
    cmp("rep_no_uf", VW'(underflow_o), '0);
    cmp("rep_cr", cr_o, va);
    pe(); idle(1);
    cmp("rep_uf", VW'(underflow_o), VW'(1));
    clr_i = 1'b1; stop_i = 1'b1; tick();
    pe(); idle(1);

    // Full FIFO, then a pop while a push is held off
    rep_i = 8'd0;
    for (int i = 0; i < DEPTH; i++) push(rnd_vec());
    cmp("full_level", VW'(level_o), VW'(DEPTH));
    cmp("full_ready", VW'(dat_ready_o), '0);
    dat_valid_i = 1'b1;
    dat_i = rnd_vec();
    tick();
    cmp("full_reject", VW'(level_o), VW'(DEPTH));
    start_i = 1'b1; tick();
    period_end_i = 1'b1; tick();
    cmp("pop_level7", VW'(level_o), VW'(DEPTH - 1));
    tick();
    dat_valid_i = 1'b0;
    cmp("refill_level8", VW'(level_o), VW'(DEPTH));
    flush_i = 1'b1; tick();
    cmp("flush_run_ignored", VW'(level_o), VW'(DEPTH));
    stop_i = 1'b1; tick();
    pe(); idle(1);
    flush_i = 1'b1; tick();
    cmp("flush_idle", VW'(level_o), '0);

    // start coincident with a boundary in IDLE: load waits for the next boundary
    vs = rnd_vec();
    push(vs);
    start_i = 1'b1; period_end_i = 1'b1; tick();
    idle(2);
    cmp("startpe_noload", VW'(level_o), VW'(1));
    pe(); idle(1);
    cmp("startpe_load", cr_o, vs);

    // clear coincident with an underflow event: set wins
    clr_i = 1'b1; period_end_i = 1'b1; tick();
    idle(1);
    cmp("clr_vs_uf", VW'(underflow_o), VW'(1));
    stop_i = 1'b1; clr_i = 1'b1; tick();
    pe(); idle(1);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      dat_valid_i  = ($urandom_range(0, 1) == 0);
      dat_i        = rnd_vec();
      period_end_i = ($urandom_range(0, 5) == 0);
      start_i      = ($urandom_range(0, 19) == 0);
      stop_i       = ($urandom_range(0, 39) == 0);
      clr_i        = ($urandom_range(0, 19) == 0);
      flush_i      = !dat_valid_i && ($urandom_range(0, 29) == 0);
      rep_i        = REPW'($urandom_range(0, 3));
      tick();
    end
    dat_valid_i = 1'b0;
    stop_i = 1'b1; tick();
    pe(); idle(2);

    // Asynchronous reset in the middle of playback
    rep_i = 8'd1;
    for (int i = 0; i < 3; i++) push(rnd_vec());
    start_i = 1'b1; tick();
    pe(); idle(2);
    #3;
    mon_en = 1'b0;
    rst_n_i = 1'b0;
    #1;
    cmp("midrst_cr", cr_o, '0);
    cmp("midrst_level", VW'(level_o), '0);
    cmp("midrst_busy", VW'(busy_o), '0);
    cmp("midrst_upd", VW'(cr_upd_o), '0);
    model_reset();
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    mon_en = 1'b1;
    idle(1);
    va = rnd_vec();
    push(va);
    start_i = 1'b1; tick();
    pe(); idle(2);
    cmp("post_rst_cr", cr_o, va);

    idle(2);
    cmp("scoreboard_drained", VW'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
